// File: rtl/nios_pio_arb_pkg.sv
// Shared types and constants for nios_pio_arbiter and its pick logic.
package nios_pio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      ACK   = 2'd3
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // The command struct is sized for the widest supported bus; the top truncates on use.
   localparam int unsigned CMD_DATA_MAX = 64;
   localparam int unsigned CMD_ADDR_MAX = 8;

   typedef struct packed {
      logic                    write;
      logic [CMD_ADDR_MAX-1:0] address;
      logic [CMD_DATA_MAX-1:0] writedata;
   } cmd_t;

endpackage

// File: rtl/nios_pio_arb_pick.sv
// Combinational two-way pick: round-robin by default, fixed priority (r0 first)
// when NIOS_PIO_ARB_FIXED_PRIO_EN is defined.
module nios_pio_arb_pick
   import nios_pio_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       valid
);

   assign valid = |req;

`ifdef NIOS_PIO_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ptr;

   always_comb begin
      grant = '0;
      if (req[REQ0]) begin
         grant[REQ0] = 1'b1;
      end else if (req[REQ1]) begin
         grant[REQ1] = 1'b1;
      end
   end
`else
   always_comb begin
      grant = req;
      if (&req) begin
         grant      = '0;
         grant[ptr] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/nios_pio_arbiter.sv
// Two-requester arbiter for a single Avalon-MM PIO slave; one transaction at a time.
// NIOS_PIO_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module nios_pio_arbiter
   import nios_pio_arb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 2,
   parameter int RESET_PTR = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              r0_req,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [DATA_W-1:0] r0_writedata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_readdata,
   input  logic              r1_req,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [DATA_W-1:0] r1_writedata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_readdata,
   output logic [ADDR_W-1:0] pio_address,
   output logic              pio_chipselect,
   output logic              pio_write_n,
   output logic [DATA_W-1:0] pio_writedata,
   input  logic [DATA_W-1:0] pio_readdata
);

   state_e            state_q, state_d;
   logic              winner_q, winner_d;
   cmd_t              cmd_q, cmd_d, sel_cmd;
   logic              cs_q, cs_d;
   logic              write_n_q, write_n_d;
   logic              r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
   logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
   logic [1:0]        grant;
   logic              grant_valid;
   logic              ptr;
   logic              ptr_d;
   logic              unused_cmd;

   nios_pio_arb_pick u_pick (
      .req   ({r1_req, r0_req}),
      .ptr   (ptr),
      .grant (grant),
      .valid (grant_valid)
   );

`ifdef NIOS_PIO_ARB_FIXED_PRIO_EN
   logic unused_ptr_d;
   assign ptr          = REQ0;
   assign unused_ptr_d = ptr_d;
`else
   logic ptr_q;
   assign ptr = ptr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= 1'(RESET_PTR);
      else          ptr_q <= ptr_d;
   end
`endif

   always_comb begin
      sel_cmd = '0;
      if (grant[REQ1]) begin
         sel_cmd.write     = r1_write;
         sel_cmd.address   = CMD_ADDR_MAX'(r1_address);
         sel_cmd.writedata = CMD_DATA_MAX'(r1_writedata);
      end else begin
         sel_cmd.write     = r0_write;
         sel_cmd.address   = CMD_ADDR_MAX'(r0_address);
         sel_cmd.writedata = CMD_DATA_MAX'(r0_writedata);
      end
   end

   // Bus strobes are set on the edge entering ISSUE so they are flop outputs during ISSUE.
   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      cmd_d      = cmd_q;
      ptr_d      = ptr;
      cs_d       = 1'b0;
      write_n_d  = 1'b1;
      r0_ack_d   = 1'b0;
      r1_ack_d   = 1'b0;
      r0_rdata_d = r0_rdata_q;
      r1_rdata_d = r1_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               winner_d  = grant[REQ1];
               cmd_d     = sel_cmd;
               cs_d      = 1'b1;
               write_n_d = ~sel_cmd.write;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_q.write) begin
               if (winner_q == REQ1) r1_ack_d = 1'b1;
               else                  r0_ack_d = 1'b1;
               state_d = ACK;
            end else begin
               state_d = CAPT;
            end
         end
         CAPT: begin
            if (winner_q == REQ1) begin
               r1_rdata_d = pio_readdata;
               r1_ack_d   = 1'b1;
            end else begin
               r0_rdata_d = pio_readdata;
               r0_ack_d   = 1'b1;
            end
            state_d = ACK;
         end
         ACK: begin
            ptr_d   = ~winner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         winner_q   <= REQ0;
         cmd_q      <= '0;
         cs_q       <= 1'b0;
         write_n_q  <= 1'b1;
         r0_ack_q   <= 1'b0;
         r1_ack_q   <= 1'b0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         cmd_q      <= cmd_d;
         cs_q       <= cs_d;
         write_n_q  <= write_n_d;
         r0_ack_q   <= r0_ack_d;
         r1_ack_q   <= r1_ack_d;
         r0_rdata_q <= r0_rdata_d;
         r1_rdata_q <= r1_rdata_d;
      end
   end

   assign unused_cmd     = ^cmd_q;
   assign pio_address    = cmd_q.address[ADDR_W-1:0];
   assign pio_writedata  = cmd_q.writedata[DATA_W-1:0];
   assign pio_chipselect = cs_q;
   assign pio_write_n    = write_n_q;
   assign r0_ack         = r0_ack_q;
   assign r1_ack         = r1_ack_q;
   assign r0_readdata    = r0_rdata_q;
   assign r1_readdata    = r1_rdata_q;

endmodule

// File: tb/tb_nios_pio_arbiter.sv
// Scoreboard bench for nios_pio_arbiter with a behavioural PIO slave.
module tb_nios_pio_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              r0_req = 1'b0, r0_write = 1'b0;
   logic [ADDR_W-1:0] r0_address = '0;
   logic [DATA_W-1:0] r0_writedata = '0;
   logic              r0_ack;
   logic [DATA_W-1:0] r0_readdata;
   logic              r1_req = 1'b0, r1_write = 1'b0;
   logic [ADDR_W-1:0] r1_address = '0;
   logic [DATA_W-1:0] r1_writedata = '0;
   logic              r1_ack;
   logic [DATA_W-1:0] r1_readdata;
   logic [ADDR_W-1:0] pio_address;
   logic              pio_chipselect, pio_write_n;
   logic [DATA_W-1:0] pio_writedata;
   logic [DATA_W-1:0] pio_readdata;
   logic [7:0]        out_port;
   logic [7:0]        in_port = 8'h00;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          who;
      bit          wr;
      logic [31:0] rdata;
   } exp_t;
   exp_t exp_q[$];

   nios_pio_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PTR(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address),
      .r0_writedata(r0_writedata), .r0_ack(r0_ack), .r0_readdata(r0_readdata),
      .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address),
      .r1_writedata(r1_writedata), .r1_ack(r1_ack), .r1_readdata(r1_readdata),
      .pio_address(pio_address), .pio_chipselect(pio_chipselect),
      .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
      .pio_readdata(pio_readdata)
   );

   always #5 clk = ~clk;

   // PIO slave: 8-bit out_port at address 0, registered readdata of in_port at address 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port     <= 8'h00;
         pio_readdata <= '0;
      end else begin
         if (pio_chipselect && !pio_write_n && pio_address == 0) out_port <= pio_writedata[7:0];
         pio_readdata <= (pio_address == 0) ? {{(DATA_W-8){1'b0}}, in_port} : '0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && (r0_ack || r1_ack)) begin
         exp_t e;
         check("ack_onehot", 64'(r0_ack) + 64'(r1_ack), 1);
         if (exp_q.size() == 0) begin
            check("ack_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("ack_who", r1_ack, e.who);
            if (!e.wr) check("ack_rdata", e.who ? r1_readdata : r0_readdata, e.rdata);
         end
      end
   end

   task automatic set_req(input bit who, input bit v);
      if (who) r1_req = v; else r0_req = v;
   endtask

   // Called at a negedge with the FSM idle; leaves one idle negedge afterwards.
   task automatic txn(input bit who, input bit wr, input logic [1:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit drop_early);
      exp_t e;
      int   n;
      e.who = who; e.wr = wr; e.rdata = exp_rd;
      exp_q.push_back(e);
      if (who) begin
         r1_write = wr; r1_address = addr; r1_writedata = wd;
      end else begin
         r0_write = wr; r0_address = addr; r0_writedata = wd;
      end
      set_req(who, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("issue_cs", pio_chipselect, 1);
            check("issue_write_n", pio_write_n, !wr);
            check("issue_addr", pio_address, addr);
            if (wr) check("issue_wdata", pio_writedata, wd);
            if (drop_early) set_req(who, 1'b0);
         end
         if (n == 2) check("cs_one_cycle", pio_chipselect, 0);
      end while (!(who ? r1_ack : r0_ack) && n < 20);
      check("latency", n, wr ? 2 : 3);
      set_req(who, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      int n, grants;
      exp_t e;
      repeat (2) @(negedge clk);
      check("rst_r0_ack", r0_ack, 0);
      check("rst_r1_ack", r1_ack, 0);
      check("rst_r0_rdata", r0_readdata, 0);
      check("rst_r1_rdata", r1_readdata, 0);
      check("rst_cs", pio_chipselect, 0);
      check("rst_write_n", pio_write_n, 1);
      check("rst_addr", pio_address, 0);
      check("rst_wdata", pio_writedata, 0);
      reset_n = 1'b1;
      @(negedge clk);

      txn(1'b0, 1'b1, 2'd0, 32'h0000_00A5, 32'h0, 1'b0);
      check("out_port_a5", out_port, 8'hA5);
      txn(1'b0, 1'b1, 2'd0, 32'h1234_56C3, 32'h0, 1'b0);
      check("out_port_c3", out_port, 8'hC3);
      txn(1'b1, 1'b1, 2'd1, 32'h0000_0011, 32'h0, 1'b0);
      check("out_port_addr1", out_port, 8'hC3);

      in_port = 8'h3C;
      txn(1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_003C, 1'b0);
      check("r0_rdata_untouched", r0_readdata, 0);
      in_port = 8'h55;
      txn(1'b0, 1'b0, 2'd0, 32'h0, 32'h0000_0055, 1'b0);
      check("r1_rdata_held", r1_readdata, 32'h3C);
      txn(1'b0, 1'b1, 2'd0, 32'h0000_0099, 32'h0, 1'b0);
      check("write_keeps_rdata", r0_readdata, 32'h55);

      // Reset while the command is on the bus.
      r0_write = 1'b1; r0_address = 2'd0; r0_writedata = 32'h77; r0_req = 1'b1;
      @(negedge clk);
      check("mid_issue_cs", pio_chipselect, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cs", pio_chipselect, 0);
      check("mid_rst_write_n", pio_write_n, 1);
      check("mid_rst_addr", pio_address, 0);
      check("mid_rst_wdata", pio_writedata, 0);
      check("mid_rst_acks", {r0_ack, r1_ack}, 0);
      check("mid_rst_rdata", r0_readdata, 0);
      r0_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_acks", {r0_ack, r1_ack}, 0);

      // Tie with both requesters held high.
      for (int i = 0; i < 4; i++) begin
`ifdef NIOS_PIO_ARB_FIXED_PRIO_EN
         e.who = 1'b0;
`else
         e.who = (i % 2 == 1);
`endif
         e.wr = 1'b1; e.rdata = '0;
         exp_q.push_back(e);
      end
      r0_write = 1'b1; r0_address = 2'd1; r0_writedata = 32'hA0;
      r1_write = 1'b1; r1_address = 2'd1; r1_writedata = 32'hB1;
      r0_req = 1'b1; r1_req = 1'b1;
      n = 0; grants = 0;
      while (grants < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (r0_ack || r1_ack) grants++;
      end
      check("tie_grants", grants, 4);
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);

      in_port = 8'h3C;
      txn(1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_003C, 1'b0);
      txn(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1);
      check("abandon_rdata_held", r1_readdata, 0);
      check("abandon_r0_untouched", r0_readdata, 0);
      repeat (3) @(negedge clk);
      check("idle_no_ack", {r0_ack, r1_ack}, 0);
      check("sb_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
